mux_nch_reg: RTL and testbench
==============================

Name: mux_nch_reg

Overview:
- Parametrised, registered N:1 channel multiplexer with valid/ready flow control on every input channel and on the output.
- Next generation of the team's flat 16:1 single-bit mux: it generalises channel count and data width, and adds an output register, backpressure, and a round-robin scan mode.
- Sits between multiple producer blocks and a single consumer (e.g. a shared datapath or serialiser) in the floorplan test designs.

Parameters:
- NUM_CH, 16, number of input channels (2..64).
- DATA_W, 8, width of each channel payload in bits.
- SEL_W, $clog2(NUM_CH), width of the select and channel-tag fields (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  packed channel payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational, at most one bit high (one-hot or zero).
- mode  input  1  0 = FIXED (external select), 1 = SCAN (round-robin).
- sel  input  SEL_W  channel select; used only in FIXED mode.
- out_data  output  DATA_W  registered payload.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, out_ch=0, scan pointer ptr=0.
  - Any held word is dropped.
  - While rst=1, in_ready is all zero.
- Load condition: can_load = !out_valid || out_ready. The output register is a single stage: a word can be replaced in the same cycle it is consumed.
- FIXED mode:
  - Chosen channel c = sel, sampled combinationally each cycle.
  - If sel >= NUM_CH (non-power-of-2 NUM_CH), there is no chosen channel: in_ready=0 and no load.
- SCAN mode:
  - c = first index j with in_valid[j]=1, searching ptr, ptr+1, ..., wrapping NUM_CH-1 -> 0.
  - If no channel is valid, there is no chosen channel.
- Grant:
  - in_ready[c] = can_load.
  - Transfer occurs when in_valid[c] && in_ready[c].
- On transfer, at the next edge:
  - out_data <= channel c payload;
  - out_ch <= c;
  - out_valid <= 1;
  - in SCAN mode only, ptr <= (c == NUM_CH-1) ? 0 : c+1.
- No transfer while out_valid && out_ready: out_valid <= 0, data and channel fields hold.
- Stalled (out_valid && !out_ready): out_data, out_ch and out_valid hold stable; in_ready is all zero.
- Latency: exactly 1 cycle from the transfer edge to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Mode switches:
  - A mode change takes effect combinationally in the same cycle; no flush.
  - ptr holds its value while in FIXED mode.
  - The word already in the output register is unaffected.
- sel changing while stalled: no effect on the held word; the new sel applies to the next load.
- Fairness: in SCAN mode with all channels continuously valid and out_ready=1, the grant order is 0,1,...,NUM_CH-1,0,...
- Reset takes priority over a simultaneous transfer.

Decomposition:
- Package mux_nch_pkg contains:
  - mode enum (MODE_FIXED=1'b0, MODE_SCAN=1'b1);
  - a localparam helper for SEL_W;
  - the default NUM_CH/DATA_W constants.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Implemented as a double-width rotate plus priority encode.
- Top level contains the select mux, in_ready decode, output register and ptr register.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release, the first transfer in SCAN mode grants channel 0.
- FIXED mode, NUM_CH=16, DATA_W=8, channel i data = 8'hA0+i, in_valid all ones, sel stepped 0..15 with out_ready=1:
  - out_data is 8'hA0..8'hAF;
  - each appears 1 cycle after its sel;
  - out_ch matches sel;
  - in_ready is one-hot at sel.
- Backpressure: FIXED mode, sel=5, out_ready=0 for 4 cycles after the first load ->
  - out_data=8'hA5 and out_valid=1 held stable;
  - in_ready=0;
  - raising out_ready gives one consume plus a same-cycle reload (no bubble).
- SCAN fairness: all in_valid=1, out_ready=1 for 20 cycles -> out_ch sequence 0..15, 0..3.
- SCAN with gaps: in_valid=16'b0000_0000_1001_0010 -> out_ch sequence 1, 4, 7, 1, 4, 7...
  - Dropping every in_valid -> out_valid falls 1 cycle later; ptr is preserved.
- Edge cases:
  - NUM_CH=12 build, FIXED mode, sel=13 -> no transfer, in_ready=0.
  - Mode switch SCAN->FIXED mid-stream -> the next grant follows sel; on returning to SCAN, scanning resumes from the saved ptr.

Source files
------------

// File: rtl/mux_nch_reg_pkg.sv
`default_nettype none
// ============================================================================
// mux_nch_pkg : shared types and constants for the N:1 registered channel mux
// Rev 1.0
// ============================================================================
package mux_nch_pkg;

  localparam int C_NUM_CH_DEF = 16;
  localparam int C_DATA_W_DEF = 8;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_SCAN  = 1'b1
  } mode_e;

  // Width of a channel index; never below one bit so ports stay legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nch_reg_if.sv
`default_nettype none
// ============================================================================
// mux_nch_reg_if : producer/consumer bundle around the N:1 channel mux
// Rev 1.0
// ============================================================================
interface mux_nch_reg_if
  import mux_nch_pkg::*;
#(
  parameter int NUM_CH = C_NUM_CH_DEF,
  parameter int DATA_W = C_DATA_W_DEF
);
  localparam int SEL_W = sel_width(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  mode_e                    mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/mux_nch_reg_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, first request at or after ptr
// Rev 1.0
// ============================================================================
module rr_pick
  import mux_nch_pkg::*;
#(
  parameter int NUM_CH = C_NUM_CH_DEF,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  wire logic [NUM_CH-1:0] i_req,
  input  wire logic [SEL_W-1:0]  i_ptr,
  output logic      [SEL_W-1:0]  o_gnt_idx,
  output logic                   o_gnt_any
);
  localparam int              C_SW1 = SEL_W + 1;
  localparam logic [SEL_W:0]  C_NCH = C_SW1'(NUM_CH);

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [SEL_W-1:0]    w_off;
  logic [SEL_W:0]      w_sum;

  // Rotating the doubled vector puts ptr at bit 0, so a plain LSB-first
  // priority encode yields the distance to the next requester.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NUM_CH];

  always_comb begin
    w_off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SEL_W'(k);
      end
    end
  end

  assign w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_gnt_idx = (w_sum >= C_NCH) ? SEL_W'(w_sum - C_NCH) : w_sum[SEL_W-1:0];
  assign o_gnt_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/mux_nch_reg.sv
`default_nettype none
// ============================================================================
// mux_nch_reg : registered N:1 channel mux, fixed-select or round-robin scan
// Rev 1.0
// ============================================================================
module mux_nch_reg
  import mux_nch_pkg::*;
#(
  parameter int NUM_CH = C_NUM_CH_DEF,
  parameter int DATA_W = C_DATA_W_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mux_nch_reg_if.slave  bus
);
  localparam int               SEL_W  = sel_width(NUM_CH);
  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(NUM_CH - 1);

  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_ch;
  logic              r_valid;
  logic [SEL_W-1:0]  r_ptr;

  logic [SEL_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_fix_ok;
  logic [SEL_W-1:0]  w_ch;
  logic              w_has;
  logic              w_can_load;
  logic [NUM_CH-1:0] w_ready;
  logic [DATA_W-1:0] w_din;
  logic              w_xfer;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .i_req     (bus.in_valid),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_pick_idx),
    .o_gnt_any (w_pick_any)
  );

  // Only non-power-of-2 channel counts can see an out-of-range select.
  if (NUM_CH == (1 << SEL_W)) begin : g_full_sel
    assign w_fix_ok = 1'b1;
  end else begin : g_part_sel
    assign w_fix_ok = (bus.sel <= C_LAST);
  end

  assign w_can_load = !r_valid || bus.out_ready;

  always_comb begin
    w_ch  = bus.sel;
    w_has = w_fix_ok;
    if (bus.mode == MODE_SCAN) begin
      w_ch  = w_pick_idx;
      w_has = w_pick_any;
    end
  end

  always_comb begin
    w_ready = '0;
    w_din   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == SEL_W'(i)) begin
        w_ready[i] = w_has && w_can_load && !rst;
        w_din      = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_xfer = |(w_ready & bus.in_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= w_din;
      r_ch    <= w_ch;
      r_valid <= 1'b1;
      if (bus.mode == MODE_SCAN) begin
        r_ptr <= (w_ch == C_LAST) ? '0 : w_ch + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_nch_reg.sv
`default_nettype none
// ============================================================================
// tb_mux_nch_reg : directed stimulus, behavioural model plus literal checks
// Rev 1.0
// ============================================================================
module tb_mux_nch_reg;
  import mux_nch_pkg::*;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int N2 = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_nch_reg_if #(.NUM_CH(N),  .DATA_W(W)) bus  ();
  mux_nch_reg_if #(.NUM_CH(N2), .DATA_W(W)) bus2 ();

  mux_nch_reg #(.NUM_CH(N),  .DATA_W(W)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mux_nch_reg #(.NUM_CH(N2), .DATA_W(W)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit       m_valid = 1'b0;
  logic [7:0] m_data = '0;
  int       m_ch  = 0;
  int       m_ptr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Channel the rules choose this cycle, from the model's own pointer.
  function automatic void model_pick(output bit has, output int c);
    has = 1'b0;
    c   = 0;
    if (bus.mode == MODE_FIXED) begin
      c   = int'(bus.sel);
      has = (c < N);
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!has && bus.in_valid[j]) begin
          has = 1'b1;
          c   = j;
        end
      end
    end
  endfunction

  function automatic logic [15:0] exp_ready();
    bit has;
    int c;
    logic [15:0] r;
    r = '0;
    if (!rst) begin
      model_pick(has, c);
      if (has && (!m_valid || bus.out_ready)) r[c] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin : p_model
    bit has;
    int c;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
    end else begin
      model_pick(has, c);
      if (has && (!m_valid || bus.out_ready) && bus.in_valid[c]) begin
        m_data  = bus.in_data[c*W +: W];
        m_ch    = c;
        m_valid = 1'b1;
        if (bus.mode == MODE_SCAN) m_ptr = (c + 1) % N;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : p_compare
    if (chk_en) begin
      chk("mdl_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("mdl_data",  64'(bus.out_data),  64'(m_data));
      chk("mdl_ch",    64'(bus.out_ch),    64'(m_ch));
      chk("mdl_ready", 64'(bus.in_ready),  64'(exp_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_gap[6] = '{4, 7, 1, 4, 7, 1};
  logic [15:0] mix_valid[4] = '{16'hFFFF, 16'h0092, 16'h8001, 16'h0000};

  initial begin
    rst            = 1'b1;
    bus.mode       = MODE_SCAN;
    bus.sel        = '0;
    bus.in_valid   = '1;
    bus.out_ready  = 1'b1;
    bus2.mode      = MODE_FIXED;
    bus2.sel       = 4'd13;
    bus2.in_valid  = '1;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < N; i++)  bus.in_data[i*W +: W]  = 8'(8'hA0 + i);
    for (int i = 0; i < N2; i++) bus2.in_data[i*W +: W] = 8'(8'hA0 + i);

    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data),  64'd0);
    chk("rst_ch",    64'(bus.out_ch),    64'd0);
    chk("rst_ready", 64'(bus.in_ready),  64'd0);
    chk("rst_ready2", 64'(bus2.in_ready), 64'd0);

    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("scan_ch",   64'(bus.out_ch),   64'(i % 16));
      chk("scan_data", 64'(bus.out_data), 64'(8'hA0 + i % 16));
      chk("n12_sel13_ready", 64'(bus2.in_ready),  64'd0);
      chk("n12_sel13_valid", 64'(bus2.out_valid), 64'd0);
    end

    bus.mode = MODE_FIXED;
    for (int i = 0; i < N; i++) begin
      bus.sel = 4'(i);
      #1;
      chk("fix_ready", 64'(bus.in_ready), 64'(16'h1 << i));
      tick();
      chk("fix_data", 64'(bus.out_data), 64'(8'hA0 + i));
      chk("fix_ch",   64'(bus.out_ch),   64'(i));
    end

    bus.sel = 4'd5;
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) bus.sel = 4'd9;
      #1;
      chk("stall_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("stall_data",  64'(bus.out_data),  64'hA5);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("reload_ready", 64'(bus.in_ready), 64'h0200);
    tick();
    chk("reload_data",  64'(bus.out_data),  64'hA9);
    chk("reload_valid", 64'(bus.out_valid), 64'd1);

    // Pointer was left at 4 by the fairness run; FIXED mode must not move it.
    bus.mode     = MODE_SCAN;
    bus.in_valid = 16'h0092;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("gap_ch", 64'(bus.out_ch), 64'(exp_gap[i]));
    end

    bus.in_valid = '0;
    tick();
    chk("drop_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 16'h0092;
    tick();
    chk("drop_resume_ch", 64'(bus.out_ch), 64'd4);

    bus.in_valid = '1;
    bus.mode     = MODE_FIXED;
    bus.sel      = 4'd12;
    tick();
    chk("sw_fixed_ch", 64'(bus.out_ch), 64'd12);
    bus.mode = MODE_SCAN;
    tick();
    chk("sw_scan_ch", 64'(bus.out_ch), 64'd5);
    tick();
    chk("sw_scan_ch2", 64'(bus.out_ch), 64'd6);

    bus2.sel = 4'd12;
    #1;
    chk("n12_sel12_ready", 64'(bus2.in_ready), 64'd0);
    tick();
    chk("n12_sel12_valid", 64'(bus2.out_valid), 64'd0);
    bus2.sel = 4'd11;
    #1;
    chk("n12_sel11_ready", 64'(bus2.in_ready), 64'h800);
    tick();
    chk("n12_sel11_valid", 64'(bus2.out_valid), 64'd1);
    chk("n12_sel11_ch",    64'(bus2.out_ch),    64'd11);
    chk("n12_sel11_data",  64'(bus2.out_data),  64'hAB);
    bus2.sel = 4'd13;
    tick();
    chk("n12_drain_valid", 64'(bus2.out_valid), 64'd0);
    chk("n12_hold_data",   64'(bus2.out_data),  64'hAB);

    for (int i = 0; i < 40; i++) begin
      bus.out_ready = (i % 3 != 2);
      bus.in_valid  = mix_valid[(i / 3) % 4];
      bus.mode      = (i < 20) ? MODE_SCAN : MODE_FIXED;
      bus.sel       = 4'((i * 7) % 16);
      tick();
    end

    bus.mode      = MODE_SCAN;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("rstprio_valid", 64'(bus.out_valid), 64'd0);
    chk("rstprio_data",  64'(bus.out_data),  64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ch", 64'(bus.out_ch), 64'd0);
    tick();
    chk("post_rst_ch2", 64'(bus.out_ch), 64'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
